// File: rtl/int_sequencer.sv
// int_sequencer: interrupt entry sequencer for the 5-stage pipeline.
// Waits for a safe point, drains the pipe, pushes EPC/flags, then vectors fetch to the handler.
module int_sequencer #(
  parameter logic [31:0] IVT_BASE     = 32'd0,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic [1:0]  int_index,
  input  logic        stall_in,
  input  logic        branch_in_flight,
  input  logic [31:0] epc_in,
  input  logic [3:0]  flags_in,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  output logic        fetch_hold,
  output logic        flush,
  output logic        mem_req,
  output logic        mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        busy,
  output logic        int_ack
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned FLG_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DRAIN    = 3'd1;
  localparam logic [2:0] S_PUSH_PC  = 3'd2;
  localparam logic [2:0] S_PUSH_FLG = 3'd3;
  localparam logic [2:0] S_VECTOR   = 3'd4;
  localparam logic [2:0] S_LOAD     = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             pending_q, pending_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [IDX_W-1:0] svc_idx_q, svc_idx_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [FLG_W-1:0] flg_q, flg_d;
  logic [XLEN-1:0]  vec_q, vec_d;

  logic             fetch_hold_q, fetch_hold_d;
  logic             flush_q, flush_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_op_q, mem_op_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic             pc_load_q, pc_load_d;
  logic [XLEN-1:0]  pc_load_value_q, pc_load_value_d;
  logic             int_ack_q, int_ack_d;

  logic             edge_c;
  logic             entry_c;

  assign edge_c  = int_req & ~prev_q;
  assign entry_c = (state_q == S_IDLE) & pending_q & ~stall_in & ~branch_in_flight;

  // Next state, data capture, and output decode from the next state so outputs leave flops.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pending_d       = pending_q;
    pend_idx_d      = pend_idx_q;
    svc_idx_d       = svc_idx_q;
    epc_d           = epc_q;
    flg_d           = flg_q;
    vec_d           = vec_q;
    fetch_hold_d    = 1'b0;
    flush_d         = 1'b0;
    mem_req_d       = 1'b0;
    mem_op_d        = 1'b0;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;
    pc_load_d       = 1'b0;
    pc_load_value_d = '0;
    int_ack_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (entry_c) begin
          state_d   = S_DRAIN;
          cnt_d     = CNT_W'(DRAIN_CYCLES - 1);
          svc_idx_d = pend_idx_q;
          epc_d     = epc_in;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_PUSH_PC;
          flg_d   = flags_in;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PUSH_PC:  if (mem_gnt) state_d = S_PUSH_FLG;
      S_PUSH_FLG: if (mem_gnt) state_d = S_VECTOR;
      S_VECTOR: begin
        if (mem_gnt) begin
          vec_d   = mem_rdata;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An edge arriving on the entry cycle re-arms pending with the new index.
    if (entry_c) pending_d = 1'b0;
    if (edge_c && (!pending_q || entry_c)) begin
      pending_d  = 1'b1;
      pend_idx_d = int_index;
    end

    fetch_hold_d = (state_d != S_IDLE);
    flush_d      = (state_q == S_IDLE) && (state_d == S_DRAIN);
    mem_req_d    = (state_d == S_PUSH_PC) || (state_d == S_PUSH_FLG) || (state_d == S_VECTOR);
    mem_op_d     = (state_d == S_VECTOR);
    if (state_d == S_VECTOR)   mem_addr_d  = IVT_BASE + XLEN'({svc_idx_d, 1'b0});
    if (state_d == S_PUSH_PC)  mem_wdata_d = epc_d;
    if (state_d == S_PUSH_FLG) mem_wdata_d = XLEN'(flg_d);
    if (state_d == S_LOAD) begin
      pc_load_d       = 1'b1;
      int_ack_d       = 1'b1;
      pc_load_value_d = vec_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      prev_q          <= 1'b1;
      pending_q       <= 1'b0;
      pend_idx_q      <= '0;
      svc_idx_q       <= '0;
      epc_q           <= '0;
      flg_q           <= '0;
      vec_q           <= '0;
      fetch_hold_q    <= 1'b0;
      flush_q         <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_op_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      pc_load_q       <= 1'b0;
      pc_load_value_q <= '0;
      int_ack_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      prev_q          <= int_req;
      pending_q       <= pending_d;
      pend_idx_q      <= pend_idx_d;
      svc_idx_q       <= svc_idx_d;
      epc_q           <= epc_d;
      flg_q           <= flg_d;
      vec_q           <= vec_d;
      fetch_hold_q    <= fetch_hold_d;
      flush_q         <= flush_d;
      mem_req_q       <= mem_req_d;
      mem_op_q        <= mem_op_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      pc_load_q       <= pc_load_d;
      pc_load_value_q <= pc_load_value_d;
      int_ack_q       <= int_ack_d;
    end
  end

  assign fetch_hold    = fetch_hold_q;
  assign busy          = fetch_hold_q;
  assign flush         = flush_q;
  assign mem_req       = mem_req_q;
  assign mem_op        = mem_op_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign pc_load       = pc_load_q;
  assign pc_load_value = pc_load_value_q;
  assign int_ack       = int_ack_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed scenarios feed an expected-transaction queue,
// a negedge monitor pops and compares every granted memory access and pc_load.
module tb_int_sequencer;

  localparam logic [31:0] IVT = 32'h0000_0100;
  localparam int unsigned D   = 3;

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_READ = 2'd1;
  localparam logic [1:0] K_LOAD = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req;
  logic [1:0]  int_index;
  logic        stall_in;
  logic        branch_in_flight;
  logic [31:0] epc_in;
  logic [3:0]  flags_in;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        fetch_hold, flush, mem_req, mem_op, pc_load, busy, int_ack;
  logic [31:0] mem_addr, mem_wdata, pc_load_value;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   flush_cnt = 0;

  int_sequencer #(.IVT_BASE(IVT), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .int_index(int_index),
    .stall_in(stall_in), .branch_in_flight(branch_in_flight),
    .epc_in(epc_in), .flags_in(flags_in), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .fetch_hold(fetch_hold), .flush(flush), .mem_req(mem_req), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .busy(busy), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  // Vector table model: entry at address A holds A + 0xFC.
  assign mem_rdata = mem_op ? (mem_addr + 32'h0000_00FC) : 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push_svc(input logic [31:0] epc, input logic [3:0] flg,
                          input logic [31:0] raddr, input logic [31:0] vec);
    exp_q.push_back('{kind: K_PUSH, addr: 32'h0, data: epc});
    exp_q.push_back('{kind: K_PUSH, addr: 32'h0, data: {28'h0, flg}});
    exp_q.push_back('{kind: K_READ, addr: raddr, data: 32'h0});
    exp_q.push_back('{kind: K_LOAD, addr: 32'h0, data: vec});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic [1:0] idx);
    int_index = idx;
    int_req   = 1'b1;
  endtask

  task automatic wait_load(input int n_in, output int n_out);
    n_out = n_in;
    for (int i = 0; i < 200 && !pc_load; i++) begin
      tick();
      n_out++;
    end
    if (!pc_load) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_load: pc_load=%b expected 1 within 200 cycles", pc_load);
    end
  endtask

  // Monitor: compares every accepted transaction and load pulse against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) flush_cnt++;
      chk("hold_eq_busy", 32'(fetch_hold), 32'(busy));
      if (mem_req && mem_gnt) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_txn: got op=%b addr=%h data=%h expected none", mem_op, mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("txn_kind", 32'(mem_op ? K_READ : K_PUSH), 32'(mon_e.kind));
          chk("txn_addr", mem_addr, mon_e.addr);
          chk("txn_wdata", mem_wdata, mon_e.data);
        end
      end
      if (pc_load || int_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_load: got pc_load=%b value=%h expected none", pc_load, pc_load_value);
        end else begin
          mon_e = exp_q.pop_front();
          chk("load_kind", 32'(K_LOAD), 32'(mon_e.kind));
          chk("load_pulse", 32'(pc_load), 32'd1);
          chk("load_ack", 32'(int_ack), 32'd1);
          chk("load_value", pc_load_value, mon_e.data);
        end
      end
      if (!mem_req) begin
        chk("idle_addr_zero", mem_addr, 32'h0);
        chk("idle_wdata_zero", mem_wdata, 32'h0);
      end
      if (!pc_load) chk("idle_pcv_zero", pc_load_value, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f0;
    rst = 1'b1; int_req = 1'b0; int_index = 2'd0; stall_in = 1'b0;
    branch_in_flight = 1'b0; epc_in = 32'h0; flags_in = 4'h0; mem_gnt = 1'b1;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hold", 32'(fetch_hold), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_pcload", 32'(pc_load), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Basic service: index 2, epc 0x40, flags 1010
    f0 = flush_cnt;
    epc_in = 32'h0000_0040; flags_in = 4'b1010;
    push_svc(32'h40, 4'hA, 32'h104, 32'h200);
    raise(2'd2); n = 0;
    tick(); n++;
    chk("basic_busy_pre", 32'(busy), 32'd0);
    tick(); n++;
    chk("basic_drain_busy", 32'(busy), 32'd1);
    chk("basic_flush_first", 32'(flush), 32'd1);
    chk("basic_drain_hold", 32'(fetch_hold), 32'd1);
    tick(); n++;
    chk("basic_flush_second", 32'(flush), 32'd0);
    int_req = 1'b0;
    wait_load(n, n);
    chk("basic_latency", 32'(n), 32'd8);
    tick();
    chk("basic_idle_after", 32'(busy), 32'd0);
    chk("basic_flush_count", 32'(flush_cnt - f0), 32'd1);
    chk("basic_queue_empty", 32'(exp_q.size()), 32'd0);

    // Blocking: stall for 4 cycles, then branch for 2
    stall_in = 1'b1;
    epc_in = 32'h1234_5678; flags_in = 4'b0101;
    push_svc(32'h1234_5678, 4'h5, 32'h106, 32'h202);
    raise(2'd3); n = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); n++;
      int_req = 1'b0;
      chk("block_stall_busy", 32'(busy), 32'd0);
    end
    stall_in = 1'b0; branch_in_flight = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); n++;
      chk("block_branch_busy", 32'(busy), 32'd0);
    end
    branch_in_flight = 1'b0;
    tick(); n++;
    chk("block_entry", 32'(busy), 32'd1);
    stall_in = 1'b1; branch_in_flight = 1'b1;
    wait_load(n, n);
    chk("block_latency", 32'(n), 32'd13);
    stall_in = 1'b0; branch_in_flight = 1'b0;
    tick();
    chk("block_idle_after", 32'(busy), 32'd0);

    // Grant stall: five refused cycles in PUSH_PC
    mem_gnt = 1'b0;
    epc_in = 32'hCAFE_0000; flags_in = 4'b0110;
    push_svc(32'hCAFE_0000, 4'h6, 32'h102, 32'h1FE);
    raise(2'd1); n = 0;
    tick(); n++;
    int_req = 1'b0;
    for (int i = 0; i < 50 && !mem_req; i++) begin
      tick(); n++;
    end
    chk("gnt_reach_push", 32'(n), 32'd5);
    for (int i = 0; i < 5; i++) begin
      tick(); n++;
      chk("gnt_req_stable", 32'(mem_req), 32'd1);
      chk("gnt_op_stable", 32'(mem_op), 32'd0);
      chk("gnt_wdata_stable", mem_wdata, 32'hCAFE_0000);
    end
    mem_gnt = 1'b1;
    wait_load(n, n);
    chk("gnt_latency", 32'(n), 32'd13);
    tick();
    chk("gnt_idle_after", 32'(busy), 32'd0);

    // Nested: second edge in DRAIN queued, third edge ignored
    epc_in = 32'h80; flags_in = 4'b0011;
    push_svc(32'h80, 4'h3, 32'h100, 32'h1FC);
    push_svc(32'h90, 4'hC, 32'h102, 32'h1FE);
    raise(2'd0); n = 0;
    tick(); n++;
    int_req = 1'b0;
    tick(); n++;
    epc_in = 32'h90;
    raise(2'd1);
    tick(); n++;
    int_req = 1'b0;
    tick(); n++;
    raise(2'd3);
    tick(); n++;
    int_req = 1'b0; flags_in = 4'b1100;
    wait_load(n, n);
    chk("nested_first_latency", 32'(n), 32'd8);
    tick();
    chk("nested_gap_busy", 32'(busy), 32'd0);
    chk("nested_gap_hold", 32'(fetch_hold), 32'd0);
    tick();
    chk("nested_second_entry", 32'(busy), 32'd1);
    n = 2;
    wait_load(n, n);
    chk("nested_second_latency", 32'(n), 32'd8);
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("nested_third_ignored", 32'(busy), 32'd0);
    end
    chk("nested_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during PUSH_FLG with int_req held high
    epc_in = 32'h44; flags_in = 4'b1111;
    exp_q.push_back('{kind: K_PUSH, addr: 32'h0, data: 32'h44});
    raise(2'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("rst_at_pushflg_wdata", mem_wdata, 32'h0000_000F);
    rst = 1'b1;
    #1;
    chk("rst_mid_hold", 32'(fetch_hold), 32'd0);
    chk("rst_mid_flush", 32'(flush), 32'd0);
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_op", 32'(mem_op), 32'd0);
    chk("rst_mid_addr", mem_addr, 32'h0);
    chk("rst_mid_wdata", mem_wdata, 32'h0);
    chk("rst_mid_pcload", 32'(pc_load), 32'd0);
    chk("rst_mid_pcv", pc_load_value, 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(int_ack), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("rst_level_no_service", 32'(busy), 32'd0);
    end
    chk("rst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Clean edge after reset
    int_req = 1'b0;
    push_svc(32'h44, 4'hF, 32'h102, 32'h1FE);
    tick();
    raise(2'd1);
    wait_load(0, n);
    chk("post_rst_latency", 32'(n), 32'd8);
    int_req = 1'b0;
    repeat (3) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
